// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control definitions: FSM state encoding, divider latency
// default, and bit positions of the bundled stall/flush control vector.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_DIV_BUSY = 2'b01,
    ST_DIV_HOLD = 2'b10
  } state_e;

  localparam int unsigned DIV_CYCLES_DEFAULT = 33;
  localparam int unsigned CNT_W_DEFAULT      = 6;
  localparam int unsigned PERF_W             = 32;

  // Bit positions within the control vector
  localparam int unsigned CTL_STALL_PC     = 0;
  localparam int unsigned CTL_STALL_IF_ID  = 1;
  localparam int unsigned CTL_STALL_ID_EX  = 2;
  localparam int unsigned CTL_STALL_EX_MEM = 3;
  localparam int unsigned CTL_STALL_MEM_WB = 4;
  localparam int unsigned CTL_FLUSH_IF_ID  = 5;
  localparam int unsigned CTL_FLUSH_ID_EX  = 6;
  localparam int unsigned CTL_FLUSH_EX_MEM = 7;
  localparam int unsigned CTL_W            = 8;

  typedef logic [CTL_W-1:0] ctl_t;

  // Data-memory wait: freeze every stage, no bubbles
  function automatic ctl_t ctl_mem_stall();
    ctl_t c;
    c = '0;
    c[CTL_STALL_PC]     = 1'b1;
    c[CTL_STALL_IF_ID]  = 1'b1;
    c[CTL_STALL_ID_EX]  = 1'b1;
    c[CTL_STALL_EX_MEM] = 1'b1;
    c[CTL_STALL_MEM_WB] = 1'b1;
    return c;
  endfunction

  // Divider active: hold front end and EX, bubble into EX/MEM
  function automatic ctl_t ctl_div();
    ctl_t c;
    c = '0;
    c[CTL_STALL_PC]     = 1'b1;
    c[CTL_STALL_IF_ID]  = 1'b1;
    c[CTL_STALL_ID_EX]  = 1'b1;
    c[CTL_FLUSH_EX_MEM] = 1'b1;
    return c;
  endfunction

  // Taken branch: squash the two younger instructions
  function automatic ctl_t ctl_branch();
    ctl_t c;
    c = '0;
    c[CTL_FLUSH_IF_ID] = 1'b1;
    c[CTL_FLUSH_ID_EX] = 1'b1;
    return c;
  endfunction

  // Load-use: hold fetch/decode, bubble into EX
  function automatic ctl_t ctl_load_use();
    ctl_t c;
    c = '0;
    c[CTL_STALL_PC]    = 1'b1;
    c[CTL_STALL_IF_ID] = 1'b1;
    c[CTL_FLUSH_ID_EX] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// 32-bit enable-gated wrapping event counter.
// Ports: clk_i, rst_ni (async active-low), en_i (count this cycle), cnt_o.
module stall_perf_counter
  import pipeline_stall_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q;
  logic [PERF_W-1:0] cnt_d;

  // Natural wrap from all-ones to zero
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush scheduler for the 5-stage rv32im pipeline. Arbitrates
// memory wait > divider > taken branch > load-use, and sequences the
// fixed-latency iterative divider (start pulse, latency count, release).
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   load_use_stall_i            load-use hazard (ID)
//   branch_taken_ex_i           taken branch/jump (EX)
//   div_op_ex_i                 divide/remainder in EX
//   dmem_req_mem_i/dmem_ready_i data memory handshake (MEM)
//   stall_*_o / flush_*_o       per-stage hold / bubble controls
//   div_start_o                 divider start pulse
//   div_result_valid_o          divider result capture enable
//   perf_*_cnt_o                stall-cycle counters
// Optional: define STALL_PERF_CNT_EN to build the performance counters;
// otherwise the perf ports are tied to zero.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_use_stall_i,
  input  logic        branch_taken_ex_i,
  input  logic        div_op_ex_i,
  input  logic        dmem_req_mem_i,
  input  logic        dmem_ready_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        stall_ex_mem_o,
  output logic        stall_mem_wb_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        flush_ex_mem_o,
  output logic        div_start_o,
  output logic        div_result_valid_o,
  output logic [31:0] perf_load_use_cnt_o,
  output logic [31:0] perf_div_stall_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  ctl_t             ctl_c;
  ctl_t             ctl_out;
  logic             div_start_c;
  logic             div_valid_c;

  assign mem_stall = dmem_req_mem_i & ~dmem_ready_i;

  // Arbitration and divider sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctl_c       = '0;
    div_start_c = 1'b0;
    div_valid_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctl_c = ctl_mem_stall();
        end else if (div_op_ex_i) begin
          div_start_c = 1'b1;
          ctl_c       = ctl_div();
          cnt_d       = CNT_W'(DIV_CYCLES - 1);
          state_d     = ST_DIV_BUSY;
        end else if (branch_taken_ex_i) begin
          ctl_c = ctl_branch();
        end else if (load_use_stall_i) begin
          ctl_c = ctl_load_use();
        end
      end
      ST_DIV_BUSY: begin
        if (cnt_q != '0) begin
          // Divider is free-running; count down even under memory wait
          cnt_d = cnt_q - CNT_W'(1);
          ctl_c = mem_stall ? ctl_mem_stall() : ctl_div();
        end else if (mem_stall) begin
          // Result ready but MEM is frozen: park until it can advance
          ctl_c   = ctl_mem_stall();
          state_d = ST_DIV_HOLD;
        end else begin
          div_valid_c = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_DIV_HOLD: begin
        if (mem_stall) begin
          ctl_c = ctl_mem_stall();
        end else begin
          div_valid_c = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, regardless of inputs
  assign ctl_out            = rst_ni ? ctl_c : '0;
  assign div_start_o        = rst_ni & div_start_c;
  assign div_result_valid_o = rst_ni & div_valid_c;

  assign stall_pc_o     = ctl_out[CTL_STALL_PC];
  assign stall_if_id_o  = ctl_out[CTL_STALL_IF_ID];
  assign stall_id_ex_o  = ctl_out[CTL_STALL_ID_EX];
  assign stall_ex_mem_o = ctl_out[CTL_STALL_EX_MEM];
  assign stall_mem_wb_o = ctl_out[CTL_STALL_MEM_WB];
  assign flush_if_id_o  = ctl_out[CTL_FLUSH_IF_ID];
  assign flush_id_ex_o  = ctl_out[CTL_FLUSH_ID_EX];
  assign flush_ex_mem_o = ctl_out[CTL_FLUSH_EX_MEM];

`ifdef STALL_PERF_CNT_EN
  logic lu_win;
  logic div_win;

  // flush_ex_mem is driven only by the divider cause; load-use is the only
  // cause that stalls PC without stalling ID/EX
  assign div_win = ctl_c[CTL_FLUSH_EX_MEM];
  assign lu_win  = ctl_c[CTL_STALL_PC] & ~ctl_c[CTL_STALL_ID_EX];

  stall_perf_counter u_perf_lu (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (lu_win),
    .cnt_o  (perf_load_use_cnt_o)
  );

  stall_perf_counter u_perf_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (div_win),
    .cnt_o  (perf_div_stall_cnt_o)
  );
`else
  assign perf_load_use_cnt_o  = 32'd0;
  assign perf_div_stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush scheduler for the rv32im 5-stage pipeline (IF, ID, EX, MEM, WB). It merges four hazard sources into one consistent set of per-stage stall and flush controls:
- load-use stall from the hazard detection unit;
- taken branch/jump resolved in EX;
- data-memory wait;
- the iterative divider.
It also sequences the multi-cycle divider: it issues the start pulse, counts its fixed latency and releases the pipeline when the result is valid.

Parameters:
DIV_CYCLES, 33, cycles from div_start_o until the divider result is valid; legal range 2..63.
CNT_W, 6, width of the divider latency counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
clk_i  input  1  pipeline clock, rising edge
rst_ni  input  1  asynchronous active-low reset
load_use_stall_i  input  1  load-use hazard from the hazard detection unit, ID stage
branch_taken_ex_i  input  1  branch/jump taken, resolved in EX
div_op_ex_i  input  1  EX holds DIV/DIVU/REM/REMU; MUL is single-cycle and is not flagged
dmem_req_mem_i  input  1  MEM stage has a load/store outstanding
dmem_ready_i  input  1  data memory completes the access this cycle
stall_pc_o  output  1  hold PC
stall_if_id_o  output  1  hold IF/ID register
stall_id_ex_o  output  1  hold ID/EX register
stall_ex_mem_o  output  1  hold EX/MEM register
stall_mem_wb_o  output  1  hold MEM/WB register
flush_if_id_o  output  1  load bubble into IF/ID
flush_id_ex_o  output  1  load bubble into ID/EX
flush_ex_mem_o  output  1  load bubble into EX/MEM
div_start_o  output  1  one-cycle start pulse to the divider
div_result_valid_o  output  1  divider result may be captured into EX/MEM this cycle
perf_load_use_cnt_o  output  32  load-use stall cycles (optional feature)
perf_div_stall_cnt_o  output  32  divider stall cycles (optional feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset state: state=RUN, counter=0, perf counters=0. All outputs 0 while rst_ni=0 and in the first cycle after reset with all inputs 0.
- Outputs are combinational from the registered state plus current inputs. Only the state, counter and perf counters are registered.
- mem_stall = dmem_req_mem_i & ~dmem_ready_i.
- Priority, highest first; only the winning cause drives outputs:
  1. mem_stall: all five stall outputs = 1; all flushes = 0; div_start_o = 0; div_result_valid_o = 0.
  2. Divider active (issue cycle, DIV_BUSY, or DIV_HOLD not yet releasing): stall_pc/if_id/id_ex = 1; flush_ex_mem = 1; load-use and branch are ignored.
  3. branch_taken_ex_i: flush_if_id = 1, flush_id_ex = 1; no stalls.
  4. load_use_stall_i: stall_pc = 1, stall_if_id = 1, flush_id_ex = 1.
- Simultaneous events:
  - Branch plus load-use: branch wins; the load-use instruction is squashed.
  - Branch during mem_stall: no flush. The branch is re-evaluated once the pipeline unfreezes.
- State RUN:
  - If div_op_ex_i & ~mem_stall, this is the issue cycle t0: div_start_o = 1, priority-2 outputs apply, counter <= DIV_CYCLES-1, next state = DIV_BUSY.
- State DIV_BUSY:
  - Counter decrements every cycle, including under mem_stall; the divider is free-running.
  - Counter != 0: priority-2 outputs.
  - Counter == 0 and ~mem_stall: div_result_valid_o = 1, no stalls, no flushes, next state = RUN. The divide instruction advances at this edge.
  - Counter == 0 and mem_stall: next state = DIV_HOLD.
- State DIV_HOLD:
  - mem_stall: priority-1 outputs.
  - Otherwise: div_result_valid_o = 1, no stalls, next state = RUN.
- Divide timing without memory wait:
  - Stall covers t0 .. t0+DIV_CYCLES-1 (DIV_CYCLES cycles).
  - div_result_valid_o is high at t0+DIV_CYCLES.
  - No re-issue for the same instruction, because EX holds a new instruction in the next cycle.
- Back-to-back divides: a second div_op_ex_i in the cycle after release issues normally.
- Reset mid-divide: returns to RUN immediately. The divider is reset by the same rst_ni.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: two 32-bit counters, each incrementing by 1 per cycle in which its cause wins arbitration. perf_load_use_cnt_o counts priority-4 cycles. perf_div_stall_cnt_o counts priority-2 cycles. Both wrap from 0xFFFFFFFF to 0.
- Undefined: no counter flops; both ports are tied to 32'd0.

Decomposition:
- Shared header pipeline_ctrl_defs:
  - state encodings RUN=2'b00, DIV_BUSY=2'b01, DIV_HOLD=2'b10;
  - DIV_CYCLES default;
  - stall/flush bit positions for use as a bundled control vector.
- Natural sub-module: stall_perf_counter, a 32-bit enable-gated wrapping counter, instantiated twice under STALL_PERF_CNT_EN.

Test Plan:
- Load-use only: load_use_stall_i=1 for 1 cycle -> stall_pc=1, stall_if_id=1, flush_id_ex=1 that cycle; all 0 the next cycle.
- Branch plus load-use in the same cycle -> flush_if_id=1, flush_id_ex=1, stall_pc=0.
- Divide, DIV_CYCLES=33, no memory wait -> div_start_o high at t0 only; stall_id_ex high t0..t0+32; div_result_valid_o high at t0+33 only; state back to RUN.
- Divide with dmem_ready_i=0 for 5 cycles spanning counter==0 -> DIV_HOLD entered; all five stalls high for those cycles; div_result_valid_o in the first cycle with ready=1.
- Memory wait plus branch -> no flush while waiting; flush in the first cycle after dmem_ready_i=1.
- rst_ni low at t0+10 of a divide -> all outputs 0 asynchronously; RUN after release; with STALL_PERF_CNT_EN, counters read 0; a preload at 0xFFFFFFFF wraps to 0 after one div stall cycle.
